// File: rtl/traffic_rr_ctrl.sv
// ---------------------------------------------------------------------------
// traffic_rr_ctrl
//   N-approach traffic-light controller. Approaches are granted green in
//   round-robin order among those whose (debounced) sensor is requesting.
//   Each grant walks GREEN -> YELLOW -> ALLRED. At most one approach is
//   non-red at any time.
//
//   A green phase only ends when some other approach is waiting. It then ends
//   once the minimum green has elapsed and the own sensor has dropped, or
//   unconditionally once the maximum green has elapsed.
//
// Ports
//   clk       clock
//   rst       synchronous reset, active-high
//   sens_i    per-approach request level, sampled every rising edge
//   green_o   green lamps, one-hot or zero
//   yel_o     yellow lamps, one-hot or zero
//   red_o     red lamps, always ~(green_o | yel_o)
//   active_o  approach currently being served, or the one last served
//   busy_o    high whenever the controller is not idle
//
// All outputs are registered and are updated in the same always_ff as the
// state, so every lamp changes on the edge where the phase changes.
// ---------------------------------------------------------------------------
module traffic_rr_ctrl #(
    parameter int NUM_DIR = 4,
    parameter int GRN_MIN = 20,
    parameter int GRN_MAX = 60,
    parameter int YEL_CYC = 6,
    parameter int RED_CLR = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_DIR-1:0]         sens_i,
    output logic [NUM_DIR-1:0]         green_o,
    output logic [NUM_DIR-1:0]         yel_o,
    output logic [NUM_DIR-1:0]         red_o,
    output logic [$clog2(NUM_DIR)-1:0] active_o,
    output logic                       busy_o
);

    localparam int AW   = $clog2(NUM_DIR);
    localparam int CMAX = (GRN_MAX > YEL_CYC) ?
                          ((GRN_MAX > RED_CLR) ? GRN_MAX : RED_CLR) :
                          ((YEL_CYC > RED_CLR) ? YEL_CYC : RED_CLR);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] C_GMIN = CW'(GRN_MIN);
    localparam logic [CW-1:0] C_GMAX = CW'(GRN_MAX);
    localparam logic [CW-1:0] C_YEL  = CW'(YEL_CYC);
    localparam logic [CW-1:0] C_RED  = CW'(RED_CLR);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_ALLRED = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;       // cycles spent in the current phase, incl. this one
    logic [AW-1:0]   ptr;       // round-robin search start

    logic [NUM_DIR-1:0] act_oh;
    logic [NUM_DIR-1:0] pick_oh;
    logic [AW-1:0]      nxt_ptr;
    logic [AW-1:0]      pick_idx;
    logic               pick_hit;
    logic               other_req;
    logic               leave_green;

    // First requesting approach at or after 'start', wrapping at NUM_DIR.
    // The loop runs backwards so the smallest offset is the last to assign
    // and therefore wins. Result MSB is the hit flag.
    function automatic logic [AW:0] rr_pick(input logic [NUM_DIR-1:0] req,
                                            input logic [AW-1:0]      start);
        logic [AW:0]   res;
        logic [AW-1:0] sel;
        int            idx;
        res = '0;
        for (int k = NUM_DIR - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % NUM_DIR;
            sel = AW'(idx);
            if (req[sel]) begin
                res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    always_comb begin
        act_oh              = NUM_DIR'(1) << active_o;
        {pick_hit, pick_idx} = rr_pick(sens_i, ptr);
        pick_oh             = NUM_DIR'(1) << pick_idx;
        nxt_ptr             = (active_o == AW'(NUM_DIR - 1)) ? '0 : active_o + AW'(1);
        other_req           = |(sens_i & ~act_oh);
        leave_green         = other_req &&
                              (((cnt >= C_GMIN) && !sens_i[active_o]) || (cnt >= C_GMAX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            active_o <= '0;
            green_o  <= '0;
            yel_o    <= '0;
            red_o    <= '1;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_hit) begin
                        state    <= ST_GREEN;
                        cnt      <= C_ONE;
                        active_o <= pick_idx;
                        green_o  <= pick_oh;
                        red_o    <= ~pick_oh;
                        busy_o   <= 1'b1;
                    end
                end

                ST_GREEN: begin
                    if (leave_green) begin
                        state   <= ST_YELLOW;
                        cnt     <= C_ONE;
                        green_o <= '0;
                        yel_o   <= act_oh;
                    end else if (cnt < C_GMAX) begin
                        // saturates so an uncontended green can last forever
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_YELLOW: begin
                    if (cnt >= C_YEL) begin
                        state <= ST_ALLRED;
                        cnt   <= C_ONE;
                        yel_o <= '0;
                        red_o <= '1;
                        // search for the next grant starts after the one just served
                        ptr   <= nxt_ptr;
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                ST_ALLRED: begin
                    if (cnt >= C_RED) begin
                        if (pick_hit) begin
                            state    <= ST_GREEN;
                            cnt      <= C_ONE;
                            active_o <= pick_idx;
                            green_o  <= pick_oh;
                            red_o    <= ~pick_oh;
                        end else begin
                            state  <= ST_IDLE;
                            cnt    <= '0;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + C_ONE;
                    end
                end

                default: begin
                    state    <= ST_IDLE;
                    cnt      <= '0;
                    green_o  <= '0;
                    yel_o    <= '0;
                    red_o    <= '1;
                    busy_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_rr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_traffic_rr_ctrl
//   Drives a 4-approach and a 3-approach controller from one sensor vector
//   (the 3-approach one sees the low three bits). A timestamp-based reference
//   model predicts the full output word after every rising edge and pushes it
//   to a per-instance expected queue; a monitor on the falling edge pops and
//   compares, and also checks the lamp invariants and logs green episodes
//   (approach, length) for the directed grant-order checks.
// ---------------------------------------------------------------------------
module tb_traffic_rr_ctrl;

    localparam int GRN_MIN = 20;
    localparam int GRN_MAX = 60;
    localparam int YEL_CYC = 6;
    localparam int RED_CLR = 2;

    localparam int P_IDLE = 0;
    localparam int P_GRN  = 1;
    localparam int P_YEL  = 2;
    localparam int P_RED  = 3;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] sens = 4'b0000;

    always #5 clk = ~clk;

    // DUT outputs
    logic [3:0] green4, yel4, red4;
    logic [1:0] act4;
    logic       busy4;
    logic [2:0] green3, yel3, red3;
    logic [1:0] act3;
    logic       busy3;

    traffic_rr_ctrl #(
        .NUM_DIR(4), .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX),
        .YEL_CYC(YEL_CYC), .RED_CLR(RED_CLR)
    ) dut4 (
        .clk(clk), .rst(rst), .sens_i(sens),
        .green_o(green4), .yel_o(yel4), .red_o(red4),
        .active_o(act4), .busy_o(busy4)
    );

    traffic_rr_ctrl #(
        .NUM_DIR(3), .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX),
        .YEL_CYC(YEL_CYC), .RED_CLR(RED_CLR)
    ) dut3 (
        .clk(clk), .rst(rst), .sens_i(sens[2:0]),
        .green_o(green3), .yel_o(yel3), .red_o(red3),
        .active_o(act3), .busy_o(busy3)
    );

    // scoreboard state
    int checks   = 0;
    int failures = 0;
    logic [14:0] exp_q0[$];
    logic [14:0] exp_q1[$];
    int ep_q0[$];           // green episodes: dir*1000 + length
    int ep_q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: phases tracked by absolute edge timestamps
    int cyc = 0;
    int m_phase[2];
    int m_dir[2];
    int m_ptr[2];
    int m_gstart[2];
    int m_end[2];

    function automatic int rr_pick(input logic [3:0] s, input int n, input int start);
        for (int k = 0; k < n; k++) begin
            if (s[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic model_grant(input int i, input int d);
        m_dir[i]    = d;
        m_phase[i]  = P_GRN;
        m_gstart[i] = cyc;
    endtask

    task automatic model_step(input int i, input int n, input logic [3:0] s_in);
        logic [3:0]  mask, s, oh, g, y, r;
        logic        busy, others;
        int          d, held;
        mask = (n == 4) ? 4'hF : 4'h7;
        s    = s_in & mask;
        if (rst) begin
            m_phase[i] = P_IDLE;
            m_dir[i]   = 0;
            m_ptr[i]   = 0;
        end else begin
            case (m_phase[i])
                P_IDLE: begin
                    d = rr_pick(s, n, m_ptr[i]);
                    if (d >= 0) model_grant(i, d);
                end
                P_GRN: begin
                    held   = cyc - m_gstart[i];
                    others = (s & ~(4'b0001 << m_dir[i])) != 4'b0000;
                    if (others && ((held >= GRN_MIN && !s[m_dir[i]]) || held >= GRN_MAX)) begin
                        m_phase[i] = P_YEL;
                        m_end[i]   = cyc + YEL_CYC;
                    end
                end
                P_YEL: begin
                    if (cyc == m_end[i]) begin
                        m_phase[i] = P_RED;
                        m_end[i]   = cyc + RED_CLR;
                        m_ptr[i]   = (m_dir[i] + 1) % n;
                    end
                end
                default: begin
                    if (cyc == m_end[i]) begin
                        d = rr_pick(s, n, m_ptr[i]);
                        if (d >= 0) model_grant(i, d);
                        else m_phase[i] = P_IDLE;
                    end
                end
            endcase
        end
        oh   = 4'b0001 << m_dir[i];
        g    = (m_phase[i] == P_GRN) ? oh : 4'b0000;
        y    = (m_phase[i] == P_YEL) ? oh : 4'b0000;
        r    = ~(g | y) & mask;
        busy = (m_phase[i] != P_IDLE);
        if (i == 0) exp_q0.push_back({busy, 2'(m_dir[i]), g, y, r});
        else        exp_q1.push_back({busy, 2'(m_dir[i]), g, y, r});
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, 4, sens);
        model_step(1, 3, sens);
    end

    // monitor
    logic [3:0] g_prev[2] = '{4'b0000, 4'b0000};
    int         run_len[2] = '{0, 0};

    function automatic int dir_of(input logic [3:0] oh);
        for (int k = 0; k < 4; k++) if (oh[k]) return k;
        return 0;
    endfunction

    task automatic mon(input int i, input logic [14:0] act);
        logic [14:0] e;
        logic [3:0]  g, y, r, mask;
        g    = act[11:8];
        y    = act[7:4];
        r    = act[3:0];
        mask = (i == 0) ? 4'hF : 4'h7;
        if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            check("exp_q_empty", 32'd1, 32'd0);
        end else begin
            if (i == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            check((i == 0) ? "outputs_n4" : "outputs_n3", 32'(act), 32'(e));
        end
        check("one_hot_lamps", 32'($countones(g | y) <= 1), 32'd1);
        check("red_is_complement", 32'(r), 32'(~(g | y) & mask));
        check("no_green_to_green",
              32'(g_prev[i] != 4'b0000 && g != 4'b0000 && g != g_prev[i]), 32'd0);
        if (g_prev[i] != 4'b0000 && g != g_prev[i]) begin
            if (i == 0) ep_q0.push_back(dir_of(g_prev[i]) * 1000 + run_len[i]);
            else        ep_q1.push_back(dir_of(g_prev[i]) * 1000 + run_len[i]);
        end
        if (g != 4'b0000) run_len[i] = (g == g_prev[i]) ? run_len[i] + 1 : 1;
        else              run_len[i] = 0;
        g_prev[i] = g;
    endtask

    always @(negedge clk) begin
        mon(0, {busy4, act4, green4, yel4, red4});
        mon(1, {busy3, act3, {1'b0, green3}, {1'b0, yel3}, {1'b0, red3}});
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        sens = 4'b0000;
        rst  = 1'b1;
        tick(n);
        rst  = 1'b0;
        ep_q0.delete();
        ep_q1.delete();
    endtask

    task automatic wait_green(input string name, input logic [3:0] m, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (green4 == m) break;
            @(negedge clk);
        end
        check(name, 32'(green4), 32'(m));
    endtask

    task automatic check_ep(input string name, input int which, input int exp);
        int v;
        v = -1;
        if (which == 0 && ep_q0.size() > 0) v = ep_q0.pop_front();
        if (which == 1 && ep_q1.size() > 0) v = ep_q1.pop_front();
        check(name, 32'(v), 32'(exp));
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_red4"},   32'(red4),   32'hF);
        check({tag, "_green4"}, 32'(green4), 32'h0);
        check({tag, "_yel4"},   32'(yel4),   32'h0);
        check({tag, "_busy4"},  32'(busy4),  32'h0);
        check({tag, "_act4"},   32'(act4),   32'h0);
        check({tag, "_red3"},   32'(red3),   32'h7);
        check({tag, "_busy3"},  32'(busy3),  32'h0);
        check({tag, "_act3"},   32'(act3),   32'h0);
    endtask

    initial begin
        // reset held three cycles with no requests
        rst  = 1'b1;
        sens = 4'b0000;
        tick(3);
        check_idle_reset("reset");
        rst = 1'b0;

        // lone request: green from the next cycle, held with no yellow
        tick(6);
        sens = 4'b0010;
        tick(1);
        check("lone_green_first", 32'(green4), 32'h2);
        tick(200);
        check("lone_green_held", 32'(green4), 32'h2);
        check("lone_no_episode", 32'(ep_q0.size()), 32'd0);

        // own sensor held, competitor from green cycle 5 -> max green
        do_reset(2);
        sens = 4'b0001;
        wait_green("maxg_start", 4'b0001, 10);
        tick(4);
        sens = 4'b0101;
        wait_green("maxg_next", 4'b0100, 120);
        check_ep("maxg_len", 0, 60);
        sens = 4'b0100;
        tick(5);

        // own sensor dropped at green cycle 3, competitor waiting -> min green
        do_reset(2);
        sens = 4'b0001;
        wait_green("ming_start", 4'b0001, 10);
        tick(2);
        sens = 4'b0010;
        wait_green("ming_next", 4'b0010, 80);
        check_ep("ming_len", 0, 20);
        tick(5);

        // all requesting: round-robin order with wrap, max green each
        do_reset(2);
        sens = 4'b1111;
        tick(5 * (GRN_MAX + YEL_CYC + RED_CLR) + 20);
        check_ep("rr4_0", 0, 0 * 1000 + 60);
        check_ep("rr4_1", 0, 1 * 1000 + 60);
        check_ep("rr4_2", 0, 2 * 1000 + 60);
        check_ep("rr4_3", 0, 3 * 1000 + 60);
        check_ep("rr4_4", 0, 0 * 1000 + 60);
        check_ep("rr3_0", 1, 0 * 1000 + 60);
        check_ep("rr3_1", 1, 1 * 1000 + 60);
        check_ep("rr3_2", 1, 2 * 1000 + 60);
        check_ep("rr3_3", 1, 0 * 1000 + 60);

        // reset during yellow cycle 3
        do_reset(2);
        sens = 4'b0011;
        wait_green("yrst_start", 4'b0001, 10);
        sens = 4'b0010;
        for (int k = 0; k < 60; k++) begin
            if (yel4 != 4'b0000) break;
            @(negedge clk);
        end
        check("yrst_in_yellow", 32'(yel4), 32'h1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_idle_reset("yrst");
        rst = 1'b0;

        // randomized traffic with occasional resets
        for (int seg = 0; seg < 40; seg++) begin
            sens = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 3));
                rst = 1'b0;
            end
            tick($urandom_range(1, 120));
        end

        sens = 4'b0000;
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
